// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache page allocator.
// Default-width typedefs match the 32-page / 4-channel configuration.
package cache_pkg;

    localparam int unsigned DefPages    = 32;
    localparam int unsigned DefChannels = 4;

    typedef logic [$clog2(DefPages)-1:0]    page_id_t;
    typedef logic [$clog2(DefChannels)-1:0] chan_id_t;

    // Free-page search order: lowest-index page first
    localparam bit LSB_TO_MSB = 1'b1;

    function automatic int unsigned cnt_width(input int unsigned pages);
        return $clog2(pages) + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins,
// wrapping from CHANNELS-1 back to 0.
module rr_arbiter #(
    parameter int unsigned CHANNELS = 4,
    localparam int unsigned CWIDTH  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic [CHANNELS-1:0] req_i,
    input  logic [CWIDTH-1:0]   ptr_i,
    output logic [CHANNELS-1:0] gnt_o,
    output logic [CWIDTH-1:0]   idx_o,
    output logic                valid_o
);

    always_comb begin
        int unsigned c;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        c       = 0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            c = (32'(ptr_i) + k) % CHANNELS;
            if (!valid_o && req_i[c]) begin
                valid_o  = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = CWIDTH'(c);
            end
        end
    end

endmodule

// File: rtl/page_pool_alloc.sv
// Multi-channel cache page allocator with round-robin grants, occupancy flags and
// double-free detection. Define PAGE_OWNER_CHECK_EN to add per-page owner checking.
module page_pool_alloc
    import cache_pkg::*;
#(
    parameter int unsigned PAGES     = 32,
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned LOW_WATER = 4,
    localparam int unsigned AWIDTH   = $clog2(PAGES),
    localparam int unsigned CWIDTH   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int unsigned CNTW     = cnt_width(PAGES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] req_i,
    output logic [CHANNELS-1:0] grant_o,
    output logic [AWIDTH-1:0]   grant_id_o,
    input  logic                clr_i,
    input  logic [AWIDTH-1:0]   clr_id_i,
    input  logic [CWIDTH-1:0]   clr_ch_i,
    input  logic                flush_i,
    output logic [CNTW-1:0]     free_cnt_o,
    output logic                page_empty_o,
    output logic                page_low_o,
    output logic                err_dbl_o,
    output logic                err_owner_o
);

    logic [PAGES-1:0]     free_q, free_d, iso;
    logic [2**AWIDTH-1:0] free_ext;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic [CWIDTH-1:0]    rr_q, rr_d, arb_idx;
    logic [CHANNELS-1:0]  arb_gnt, grant_q, grant_d;
    logic [AWIDTH-1:0]    pg_id, grant_id_q, grant_id_d;
    logic                 arb_valid, do_grant, do_rel, clr_hit_free, owner_bad;
    logic                 err_dbl_q, err_dbl_d, err_owner_q, err_owner_d;

    rr_arbiter #(
        .CHANNELS(CHANNELS)
    ) u_arb (
        .req_i  (req_i),
        .ptr_i  (rr_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx),
        .valid_o(arb_valid)
    );

    always_comb begin
        if (LSB_TO_MSB) begin
            iso = free_q & ~(free_q - PAGES'(1));
        end else begin
            iso = '0;
            for (int unsigned i = 0; i < PAGES; i++) begin
                if (free_q[i]) iso = PAGES'(1) << i;
            end
        end
        pg_id = '0;
        for (int unsigned i = 0; i < PAGES; i++) begin
            if (iso[i]) pg_id = AWIDTH'(i);
        end
    end

    // Out-of-range ids read as free so they report as a double-free
    always_comb begin
        free_ext              = '0;
        free_ext[PAGES-1:0]   = free_q;
        clr_hit_free          = (32'(clr_id_i) >= PAGES) || free_ext[clr_id_i];
    end

`ifdef PAGE_OWNER_CHECK_EN
    logic [CWIDTH-1:0] owner_q [2**AWIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2**AWIDTH; i++) owner_q[i] <= '0;
        end else if (do_grant) begin
            owner_q[pg_id] <= arb_idx;
        end
    end

    assign owner_bad = clr_i && !clr_hit_free && (owner_q[clr_id_i] != clr_ch_i);
`else
    logic unused_clr_ch;
    assign unused_clr_ch = ^clr_ch_i;
    assign owner_bad     = 1'b0;
`endif

    always_comb begin
        do_grant    = arb_valid && (|free_q) && !flush_i;
        do_rel      = clr_i && !clr_hit_free && !owner_bad && !flush_i;
        err_dbl_d   = clr_i && clr_hit_free && !flush_i;
        err_owner_d = owner_bad && !flush_i;
        free_d      = free_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        grant_d     = '0;
        grant_id_d  = '0;
        if (flush_i) begin
            free_d = '1;
            cnt_d  = CNTW'(PAGES);
        end else begin
            if (do_grant) begin
                free_d     = free_d & ~iso;
                grant_d    = arb_gnt;
                grant_id_d = pg_id;
                rr_d       = (32'(arb_idx) == CHANNELS - 1) ? '0 : arb_idx + 1'b1;
            end
            // Selection above used the pre-release vector, so a released page waits a cycle
            for (int unsigned i = 0; i < PAGES; i++) begin
                if (do_rel && (32'(clr_id_i) == i)) free_d[i] = 1'b1;
            end
            cnt_d = cnt_q + CNTW'(do_rel) - CNTW'(do_grant);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_q      <= '1;
            cnt_q       <= CNTW'(PAGES);
            rr_q        <= '0;
            grant_q     <= '0;
            grant_id_q  <= '0;
            err_dbl_q   <= 1'b0;
            err_owner_q <= 1'b0;
        end else begin
            free_q      <= free_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            grant_id_q  <= grant_id_d;
            err_dbl_q   <= err_dbl_d;
            err_owner_q <= err_owner_d;
        end
    end

    assign grant_o      = grant_q;
    assign grant_id_o   = grant_id_q;
    assign free_cnt_o   = cnt_q;
    assign page_empty_o = (cnt_q == '0);
    assign page_low_o   = (32'(cnt_q) <= LOW_WATER);
    assign err_dbl_o    = err_dbl_q;
    assign err_owner_o  = err_owner_q;

endmodule

// File: tb/tb_page_pool_alloc.sv
// Self-checking bench for page_pool_alloc: directed scenarios plus random traffic
// checked against a set-based reference model of the page pool.
module tb_page_pool_alloc;

    localparam int P  = 32;
    localparam int C  = 4;
    localparam int LW = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       clr;
    logic [4:0] clr_id;
    logic [1:0] clr_ch;
    logic       flush;
    logic [3:0] grant;
    logic [4:0] grant_id;
    logic [5:0] free_cnt;
    logic       page_empty, page_low, err_dbl, err_owner;

    // Second instance with a non-power-of-two pool to reach out-of-range release ids
    logic       clr2;
    logic [4:0] clr2_id;
    logic [3:0] grant2;
    logic [4:0] grant2_id;
    logic [5:0] free_cnt2;
    logic       page_empty2, page_low2, err_dbl2, err_owner2;

    int errors = 0;
    int checks = 0;

    bit         m_free [P];
    int         m_owner[P];
    int         m_rr;
    logic [3:0] e_grant;
    int         e_id;
    bit         e_dbl, e_own;

    always #5 clk = ~clk;

    page_pool_alloc #(.PAGES(P), .CHANNELS(C), .LOW_WATER(LW)) u_dut (
        .clk(clk), .rst(rst), .req_i(req), .grant_o(grant), .grant_id_o(grant_id),
        .clr_i(clr), .clr_id_i(clr_id), .clr_ch_i(clr_ch), .flush_i(flush),
        .free_cnt_o(free_cnt), .page_empty_o(page_empty), .page_low_o(page_low),
        .err_dbl_o(err_dbl), .err_owner_o(err_owner)
    );

    page_pool_alloc #(.PAGES(20), .CHANNELS(C), .LOW_WATER(LW)) u_dut2 (
        .clk(clk), .rst(rst), .req_i(4'b0000), .grant_o(grant2), .grant_id_o(grant2_id),
        .clr_i(clr2), .clr_id_i(clr2_id), .clr_ch_i(2'b00), .flush_i(1'b0),
        .free_cnt_o(free_cnt2), .page_empty_o(page_empty2), .page_low_o(page_low2),
        .err_dbl_o(err_dbl2), .err_owner_o(err_owner2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < P; i++) n += m_free[i];
        return n;
    endfunction

    // Advance the reference pool by one clock using the inputs currently driven
    task automatic model_step();
        int p, w, c;
        bit rel;
        e_grant = '0;
        e_id    = 0;
        e_dbl   = 1'b0;
        e_own   = 1'b0;
        if (flush) begin
            for (int i = 0; i < P; i++) m_free[i] = 1'b1;
            return;
        end
        p = -1;
        for (int i = P - 1; i >= 0; i--) if (m_free[i]) p = i;
        w = -1;
        for (int k = 0; k < C; k++) begin
            c = (m_rr + k) % C;
            if (w < 0 && req[c]) w = c;
        end
        rel = 1'b0;
        if (clr) begin
            if (int'(clr_id) >= P || m_free[clr_id]) e_dbl = 1'b1;
`ifdef PAGE_OWNER_CHECK_EN
            else if (m_owner[clr_id] != int'(clr_ch)) e_own = 1'b1;
`endif
            else rel = 1'b1;
        end
        if (w >= 0 && p >= 0) begin
            m_free[p]  = 1'b0;
            m_owner[p] = w;
            e_grant[w] = 1'b1;
            e_id       = p;
            m_rr       = (w + 1) % C;
        end
        if (rel) m_free[clr_id] = 1'b1;
    endtask

    task automatic check_all();
        chk("grant", grant, e_grant);
        if (e_grant != 0) chk("grant_id", grant_id, e_id);
        chk("free_cnt", free_cnt, m_count());
        chk("page_empty", page_empty, m_count() == 0);
        chk("page_low", page_low, m_count() <= LW);
        chk("err_dbl", err_dbl, e_dbl);
        chk("err_owner", err_owner, e_own);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        logic [3:0] rot [5];
        rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        rst = 1'b1; req = '0; clr = 1'b0; clr_id = '0; clr_ch = '0; flush = 1'b0;
        clr2 = 1'b0; clr2_id = '0;
        for (int i = 0; i < P; i++) begin
            m_free[i]  = 1'b1;
            m_owner[i] = 0;
        end
        m_rr = 0; e_grant = '0; e_id = 0; e_dbl = 1'b0; e_own = 1'b0;

        #12;
        check_all();
        chk("reset_cnt", free_cnt, 32);
        chk("reset_low", page_low, 1'b0);
        chk("dut2_reset_cnt", free_cnt2, 20);
        rst = 1'b0;

        // Out-of-range and in-range double-free on the 20-page instance
        clr2 = 1'b1; clr2_id = 5'd25;
        cycle();
        chk("dut2_oor_dbl", err_dbl2, 1'b1);
        chk("dut2_oor_cnt", free_cnt2, 20);
        clr2_id = 5'd19;
        cycle();
        chk("dut2_free_dbl", err_dbl2, 1'b1);
        clr2 = 1'b0;
        cycle();
        chk("dut2_dbl_clear", err_dbl2, 1'b0);

        // All channels requesting: grants rotate, ids ascend
        req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("rot_grant", grant, rot[i]);
            chk("rot_id", grant_id, i);
        end
        req = 4'h0; flush = 1'b1;
        cycle();
        flush = 1'b0;

        // Single requester drains the pool in order, then stalls
        req = 4'b0001;
        for (int i = 0; i < 33; i++) begin
            cycle();
            if (i < 32) chk("fill_id", grant_id, i);
            chk("fill_grant", grant, (i < 32) ? 4'b0001 : 4'b0000);
        end
        chk("fill_empty", page_empty, 1'b1);

        // Release into an empty pool: not grantable until the following cycle
        clr = 1'b1; clr_id = 5'd7;
        cycle();
        chk("clr7_nogrant", grant, 4'b0000);
        chk("clr7_cnt1", free_cnt, 1);
        clr = 1'b0;
        cycle();
        chk("clr7_grant", grant, 4'b0001);
        chk("clr7_id", grant_id, 7);
        chk("clr7_cnt0", free_cnt, 0);
        req = 4'h0;

        // Double release of page 5
        clr = 1'b1; clr_id = 5'd5;
        cycle();
        cycle();
        chk("dbl_pulse", err_dbl, 1'b1);
        chk("dbl_cnt", free_cnt, 1);
        clr = 1'b0;
        cycle();
        chk("dbl_clear", err_dbl, 1'b0);

        // Flush with concurrent request and release
        flush = 1'b1;
        cycle();
        flush = 1'b0; req = 4'b0001;
        repeat (10) cycle();
        chk("pre_flush_cnt", free_cnt, 22);
        flush = 1'b1; req = 4'hF; clr = 1'b1; clr_id = 5'd2;
        cycle();
        chk("flush_cnt", free_cnt, 32);
        chk("flush_grant", grant, 4'b0000);
        chk("flush_err", err_dbl, 1'b0);
        flush = 1'b0; clr = 1'b0; req = 4'h0;

        // Channel 2 owns page 3; wrong-channel release vs. owner release
        req = 4'b0001;
        repeat (3) cycle();
        req = 4'b0100;
        cycle();
        chk("own_grant", grant, 4'b0100);
        chk("own_id", grant_id, 3);
        req = 4'h0; clr = 1'b1; clr_id = 5'd3; clr_ch = 2'd1;
        cycle();
`ifdef PAGE_OWNER_CHECK_EN
        chk("own_err", err_owner, 1'b1);
        chk("own_kept", free_cnt, 28);
`endif
        clr_ch = 2'd2;
        cycle();
`ifdef PAGE_OWNER_CHECK_EN
        chk("own_freed", free_cnt, 29);
`endif
        clr = 1'b0;
        cycle();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            req    = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
            clr    = ($urandom_range(0, 3) != 0);
            clr_id = 5'($urandom_range(0, P - 1));
            clr_ch = 2'($urandom_range(0, C - 1));
            flush  = ($urandom_range(0, 49) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
